fetch_stage: RTL



---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_stage.sv | 91 +++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: address/instruction widths and the fetch control state.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  typedef logic [ADDR_W-1:0]  pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// PC/fetch control feeding a 1-cycle synchronous-read instruction memory.
// Latency: address issued this cycle, word+PC valid next cycle; stall re-reads the displayed word.
module fetch_stage #(
  parameter int unsigned     ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned     INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [ADDR_W-1:0]  imem_address,
  input  logic [INSTR_W-1:0] imem_instruction,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instruction,
  output logic [CNT_W-1:0]   fetch_count
);

  import cpu_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr;

  // pc_q always holds the address after if_pc_q, so the memory is one step ahead.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    cnt_d      = cnt_q;
    addr       = RESET_PC;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          if_pc_d    = RESET_PC;
          pc_d       = RESET_PC + ADDR_W'(1);
          if_valid_d = 1'b1;
        end
      end
      RUN: begin
        if (if_valid_q && !stall && !redirect) cnt_d = cnt_q + CNT_W'(1);
        if (redirect) begin
          addr       = redirect_target;
          if_pc_d    = redirect_target;
          pc_d       = redirect_target + ADDR_W'(1);
          if_valid_d = 1'b1;
        end else if (stall) begin
          addr = if_pc_q;
        end else begin
          addr       = pc_q;
          if_pc_d    = pc_q;
          pc_d       = pc_q + ADDR_W'(1);
          if_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= RESET_PC;
      if_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign imem_address   = addr;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instruction = imem_instruction;
  assign fetch_count    = cnt_q;

endmodule
